// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery modular multiplier: FSM states,
// datapath operation codes and the m_size port width helper.
package montgomery_pkg;

    // Sequencing states of the two-pass multiply.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_RED1 = 3'd2,
        ST_MUL2 = 3'd3,
        ST_RED2 = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Commands issued by the sequencer to the MonPro datapath.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0, // keep accumulator and x register
        OP_LOAD = 2'd1, // load x, clear accumulator (start of a MonPro)
        OP_STEP = 2'd2, // PBITS radix-2 steps, consume PBITS bits of x
        OP_RED  = 2'd3  // store conditionally-subtracted accumulator
    } core_op_e;

    // Width of the m_size port; wide enough to hold NBITS itself plus headroom.
    function automatic int msize_width(input int nbits);
        return $clog2(nbits) + 3;
    endfunction

endpackage

// File: rtl/montgomery_core.sv
// MonPro datapath: NBITS+2-bit accumulator, PBITS-step unrolled radix-2
// interleaved Montgomery reduction and the final conditional subtraction.
// x is held in a shift register and consumed LSB first.
module montgomery_core
    import montgomery_pkg::*;
#(
    parameter int NBITS = 4096,
    parameter int PBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  core_op_e         op_i,
    input  logic [NBITS-1:0] x_i,
    input  logic [NBITS-1:0] z_i,
    input  logic [NBITS-1:0] m_i,
    output logic [NBITS-1:0] res_o
);

    localparam int SW = NBITS + 2;

    logic [SW-1:0]    s_q;
    logic [SW-1:0]    s_d;
    logic [SW-1:0]    s_step;
    logic [NBITS-1:0] x_q;
    logic [NBITS-1:0] x_d;
    logic             s_ge_m;

    // PBITS radix-2 steps: add xi*z, make even by adding m, halve.
    always_comb begin : step_logic
        logic [SW-1:0] acc;
        acc = s_q;
        for (int i = 0; i < PBITS; i++) begin
            if (x_q[i]) begin
                acc = acc + {2'b00, z_i};
            end
            if (acc[0]) begin
                acc = acc + {2'b00, m_i};
            end
            acc = {1'b0, acc[SW-1:1]};
        end
        s_step = acc;
    end

    // Final reduction: S < 2m after a MonPro, so one subtraction suffices.
    always_comb begin
        s_ge_m = (s_q >= {2'b00, m_i});
        res_o  = s_ge_m ? (s_q[NBITS-1:0] - m_i) : s_q[NBITS-1:0];
    end

    // Next-state selection for accumulator and x shift register.
    always_comb begin
        s_d = s_q;
        x_d = x_q;
        case (op_i)
            OP_LOAD: begin
                s_d = '0;
                x_d = x_i;
            end
            OP_STEP: begin
                s_d = s_step;
                x_d = x_q >> PBITS;
            end
            OP_RED: begin
                s_d = {2'b00, res_o};
            end
            default: begin
                s_d = s_q;
                x_d = x_q;
            end
        endcase
    end

    // Datapath registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
            x_q <= '0;
        end else begin
            s_q <= s_d;
            x_q <= x_d;
        end
    end

endmodule

// File: rtl/montgomery_wrap.sv
// Montgomery modular multiplier y = a*b mod m, computed as
// MonPro(MonPro(a,b), R^2 mod m) with R = 2^m_size.
// Handshake: enable_p is a one-cycle start pulse honoured only in IDLE;
// done_irq_p is a one-cycle pulse in the DONE state, when y holds the result.
// Optional macro MONT_ASSERT_EN compiles operand-legality assertions.
module montgomery_wrap
    import montgomery_pkg::*;
#(
    parameter int NBITS = 4096,
    parameter int PBITS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable_p,
    input  logic [NBITS-1:0]                 a,
    input  logic [NBITS-1:0]                 b,
    input  logic [NBITS-1:0]                 m,
    input  logic [msize_width(NBITS)-1:0]    m_size,
    input  logic [NBITS-1:0]                 r_red,
    output logic [NBITS-1:0]                 y,
    output logic                             done_irq_p
);

    localparam int MW = msize_width(NBITS);

    state_e           state_q;
    state_e           state_d;
    logic [MW-1:0]    cnt_q;
    logic [MW-1:0]    cnt_d;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] m_q;
    logic [NBITS-1:0] rred_q;
    logic [MW-1:0]    msize_q;
    logic [NBITS-1:0] y_q;
    logic [NBITS-1:0] y_d;
    logic             capture;
    logic             last_step;
    core_op_e         core_op;
    logic [NBITS-1:0] core_x;
    logic [NBITS-1:0] core_z;
    logic [NBITS-1:0] core_res;

    // cnt_q counts bits of x consumed in the current MonPro.
    assign last_step = ((cnt_q + MW'(PBITS)) >= msize_q);

    // Next-state and datapath control; a is loaded into the core directly
    // on capture, the pass-1 result is reloaded as x for pass 2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        capture = 1'b0;
        core_op = OP_HOLD;
        core_x  = a;
        core_z  = b_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_p) begin
                    capture = 1'b1;
                    core_op = OP_LOAD;
                    core_x  = a;
                    cnt_d   = '0;
                    state_d = ST_MUL1;
                end
            end
            ST_MUL1: begin
                core_op = OP_STEP;
                core_z  = b_q;
                cnt_d   = cnt_q + MW'(PBITS);
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = ST_RED1;
                end
            end
            ST_RED1: begin
                core_op = OP_LOAD;
                core_x  = core_res;
                state_d = ST_MUL2;
            end
            ST_MUL2: begin
                core_op = OP_STEP;
                core_z  = rred_q;
                cnt_d   = cnt_q + MW'(PBITS);
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = ST_RED2;
                end
            end
            ST_RED2: begin
                core_op = OP_RED;
                y_d     = core_res;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, step counter and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    // Operand capture so later input changes cannot disturb the operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q     <= '0;
            m_q     <= '0;
            rred_q  <= '0;
            msize_q <= '0;
        end else if (capture) begin
            b_q     <= b;
            m_q     <= m;
            rred_q  <= r_red;
            msize_q <= m_size;
        end
    end

    montgomery_core #(
        .NBITS (NBITS),
        .PBITS (PBITS)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .op_i  (core_op),
        .x_i   (core_x),
        .z_i   (core_z),
        .m_i   (m_q),
        .res_o (core_res)
    );

    assign y          = y_q;
    assign done_irq_p = (state_q == ST_DONE);

`ifdef MONT_ASSERT_EN
    // Flag illegal operands at the moment a start is accepted.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_IDLE) && enable_p) begin
            assert (m[0]) else $error("montgomery_wrap: modulus is even");
            assert (m_size != '0) else $error("montgomery_wrap: m_size is zero");
            assert (m_size <= MW'(NBITS)) else $error("montgomery_wrap: m_size exceeds NBITS");
            assert ((m_size % MW'(PBITS)) == '0) else $error("montgomery_wrap: m_size not a multiple of PBITS");
            assert (a < m) else $error("montgomery_wrap: a >= m");
            assert (b < m) else $error("montgomery_wrap: b >= m");
        end
    end
`endif

endmodule

// File: tb/tb_montgomery_wrap.sv
// Bench for montgomery_wrap: directed steps on an NBITS=16/PBITS=4 instance,
// random operands on an NBITS=16/PBITS=1 instance, expected results queued
// when an operation is started and compared when done_irq_p fires.
module tb_montgomery_wrap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en4, en1;
    logic [15:0] a4, b4, m4, rr4, y4;
    logic [15:0] a1, b1, m1, rr1, y1;
    logic [6:0]  ms4, ms1;
    logic        done4, done1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    montgomery_wrap #(.NBITS(16), .PBITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable_p(en4), .a(a4), .b(b4), .m(m4),
        .m_size(ms4), .r_red(rr4), .y(y4), .done_irq_p(done4)
    );

    montgomery_wrap #(.NBITS(16), .PBITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable_p(en1), .a(a1), .b(b1), .m(m1),
        .m_size(ms1), .r_red(rr1), .y(y1), .done_irq_p(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                          input logic [6:0] ms, input logic [15:0] rr, input logic [15:0] exp);
        @(negedge clk);
        a4 = a; b4 = b; m4 = m; ms4 = ms; rr4 = rr;
        en4 = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic start1(input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                          input logic [6:0] ms, input logic [15:0] rr, input logic [15:0] exp);
        @(negedge clk);
        a1 = a; b1 = b; m1 = m; ms1 = ms; rr1 = rr;
        en1 = 1'b1;
        exp_q.push_back(exp);
    endtask

    // Count edges until done; scramble inputs after capture each cycle.
    task automatic wait_done(input bit sel, input int exp_lat, input string tag);
        int          cnt;
        bit          seen;
        logic [15:0] exp;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            en4 = 1'b0; en1 = 1'b0;
            a4 = 16'($urandom); b4 = 16'($urandom); m4 = 16'($urandom);
            rr4 = 16'($urandom); ms4 = 7'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); m1 = 16'($urandom);
            rr1 = 16'($urandom); ms1 = 7'($urandom);
            seen = sel ? done1 : done4;
        end
        check({tag, ".done"}, 32'(seen), 32'd1);
        check({tag, ".lat"}, 32'(cnt), 32'(exp_lat));
        exp = exp_q.pop_front();
        check({tag, ".y"}, 32'(sel ? y1 : y4), 32'(exp));
    endtask

    task automatic no_done(input int ncyc, input string tag);
        int pulses;
        pulses = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (done4) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        longint mm, aa, bb, rr;
        rst_n = 1'b0;
        en4 = 1'b0; en1 = 1'b0;
        a4 = '0; b4 = '0; m4 = '0; rr4 = '0; ms4 = '0;
        a1 = '0; b1 = '0; m1 = '0; rr1 = '0; ms1 = '0;
        repeat (3) @(negedge clk);
        check("rst.y4", 32'(y4), 32'd0);
        check("rst.done4", 32'(done4), 32'd0);
        check("rst.y1", 32'(y1), 32'd0);
        check("rst.done1", 32'(done1), 32'd0);
        rst_n = 1'b1;

        // K=4: (0xFFFE*0xFFFC) mod 0xFFFF = 3, R^2 mod m = 1
        start4(16'hFFFE, 16'hFFFC, 16'hFFFF, 7'd16, 16'd1, 16'd3);
        wait_done(1'b0, 11, "m_ffff");

        // K=1, m=13, R=16, R^2 mod 13 = 9
        start4(16'd5, 16'd7, 16'd13, 7'd4, 16'd9, 16'd9);
        wait_done(1'b0, 5, "m13_5x7");
        start4(16'd0, 16'd12, 16'd13, 7'd4, 16'd9, 16'd0);
        wait_done(1'b0, 5, "m13_0x12");
        start4(16'd1, 16'd1, 16'd13, 7'd4, 16'd9, 16'd1);
        wait_done(1'b0, 5, "m13_1x1");
        start4(16'd12, 16'd12, 16'd13, 7'd4, 16'd9, 16'd1);
        wait_done(1'b0, 5, "m13_12x12");

        // K=2, m=251, R=256, R^2 mod 251 = 25; 200*100 mod 251 = 171
        start4(16'd200, 16'd100, 16'd251, 7'd8, 16'd25, 16'd171);
        wait_done(1'b0, 7, "m251");

        // enable in the DONE cycle is ignored, y holds
        a4 = 16'd3; b4 = 16'd3; m4 = 16'd13; ms4 = 7'd4; rr4 = 16'd9;
        en4 = 1'b1;
        @(negedge clk);
        en4 = 1'b0;
        no_done(15, "done_cycle_en");
        check("done_cycle_en.y_hold", 32'(y4), 32'd171);

        // second enable mid-operation is ignored
        start4(16'hFFFE, 16'hFFFC, 16'hFFFF, 7'd16, 16'd1, 16'd3);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            en4 = 1'b0;
        end
        a4 = 16'd1; b4 = 16'd1; m4 = 16'hFFFF; ms4 = 7'd16; rr4 = 16'd1;
        en4 = 1'b1;
        wait_done(1'b0, 9, "midop_en");
        no_done(20, "midop_single");

        // reset mid-operation aborts with no pulse
        start4(16'hFFFE, 16'hFFFC, 16'hFFFF, 7'd16, 16'd1, 16'd3);
        @(negedge clk);
        en4 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_front());
        check("midrst.y", 32'(y4), 32'd0);
        check("midrst.done", 32'(done4), 32'd0);
        no_done(20, "midrst.no_done");
        check("midrst.y_after", 32'(y4), 32'd0);
        start4(16'd12, 16'd12, 16'd13, 7'd4, 16'd9, 16'd1);
        wait_done(1'b0, 5, "after_rst");

        // random odd moduli on the PBITS=1 instance
        for (int i = 0; i < 1000; i++) begin
            mm = 2 * longint'($urandom_range(1, 32767)) + 1;
            aa = longint'($urandom_range(0, 32'(mm - 1)));
            bb = longint'($urandom_range(0, 32'(mm - 1)));
            rr = 65536 % mm;
            rr = (rr * rr) % mm;
            start1(16'(aa), 16'(bb), 16'(mm), 7'd16, 16'(rr), 16'((aa * bb) % mm));
            wait_done(1'b1, 35, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/montgomery_wrap.md
MONTGOMERY_WRAP -- requirements
Module: montgomery_wrap

Interface
REQ-001 Parameter NBITS, default 4096: maximum operand/modulus width in bits.
REQ-002 Parameter PBITS, default 8: bits of operand a consumed per clock; NBITS SHALL be a multiple of PBITS.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable_p  input  1  one-cycle start pulse.
REQ-006 a  input  NBITS  multiplicand, a < m.
REQ-007 b  input  NBITS  multiplier, b < m.
REQ-008 m  input  NBITS  odd modulus; bits at and above m_size are zero.
REQ-009 m_size  input  $clog2(NBITS)+3  modulus width in bits; multiple of PBITS, 1..NBITS.
REQ-010 r_red  input  NBITS  precomputed R^2 mod m, where R = 2^m_size.
REQ-011 y  output  NBITS  result a*b mod m.
REQ-012 done_irq_p  output  1  one-cycle completion pulse.

Function
REQ-013 The block SHALL compute y = (a*b) mod m, fully reduced, so 0 <= y < m.
REQ-014 Method: T = MonPro(a,b) = a*b*R^-1 mod m; then y = MonPro(T, r_red).
REQ-015 MonPro(x,z) SHALL use radix-2 interleaved Montgomery reduction on an NBITS+2-bit accumulator S, starting at S=0.
REQ-016 Each radix-2 step for bit xi SHALL compute S = S + xi*z, then add m if S is odd, then shift S right by 1.
REQ-017 Each clock SHALL perform PBITS radix-2 steps combinationally, LSB of x first.
REQ-018 Each MonPro SHALL run K = m_size/PBITS cycles.
REQ-019 Each MonPro SHALL end with a one-cycle conditional subtraction: if S >= m, then S = S - m.
REQ-020 FSM states: IDLE, MUL1 (K cycles), RED1 (1), MUL2 (K), RED2 (1), DONE (1), then return to IDLE.
REQ-021 In IDLE, enable_p=1 SHALL capture a, b, m, m_size and r_red into internal registers and enter MUL1; input changes after capture SHALL have no effect on the result.
REQ-022 enable_p outside IDLE SHALL be ignored.
REQ-023 In DONE, done_irq_p SHALL be 1 and y SHALL hold the result; done_irq_p asserts exactly 2K+3 rising edges after the edge that sampled enable_p.
REQ-024 y SHALL hold the last result until the next DONE; y is not updated in any other state.
REQ-025 enable_p in the DONE cycle SHALL be ignored; a new operation may start from the IDLE cycle that follows.
REQ-026 Result is unspecified if m is even, a >= m, b >= m, or m_size is not a multiple of PBITS.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force: state to IDLE, y to 0, done_irq_p to 0, and all working registers to 0.
REQ-028 Reset mid-operation SHALL abort the operation with no done_irq_p pulse.
REQ-029 The first enable_p after reset release SHALL be accepted normally.

Configuration
REQ-030 Macro MONT_ASSERT_EN defined: simulation assertions SHALL flag, at enable_p in IDLE, any of: m even, m_size zero, m_size > NBITS, m_size not a multiple of PBITS, a >= m, b >= m.
REQ-031 MONT_ASSERT_EN undefined: no assertion code is compiled, and functional behaviour is identical.

Structure
REQ-032 Shared package montgomery_pkg SHALL hold the FSM state enum and a width function for m_size ($clog2(NBITS)+3).
REQ-033 Sub-module montgomery_core SHALL implement the MonPro datapath: accumulator, PBITS-step unrolled radix-2 logic and final subtraction.
REQ-034 montgomery_wrap SHALL hold the FSM, input capture, two-pass sequencing, y register and done_irq_p.

Verification
REQ-035 NBITS=16, PBITS=4, m=0xFFFF, m_size=16, r_red=1, a=0xFFFE, b=0xFFFC -> y=3, done_irq_p 11 cycles after enable_p.
REQ-036 NBITS=16, PBITS=4, m=13, m_size=4, r_red=9, a=5, b=7 -> y=9, done 5 cycles after enable_p.
REQ-037 Same m=13 setup: a=0, b=12 -> y=0; a=1, b=1 -> y=1; a=12, b=12 -> y=1.
REQ-038 Second enable_p mid-operation -> ignored, exactly one done pulse; rst_n=0 mid-operation -> no done pulse, y=0, next operation correct.
REQ-039 PBITS=1, NBITS=16, 1000 random odd m with m_size=16, r_red from a software model, random a,b < m -> y matches a*b mod m, latency 2*16+3 cycles.
